// File: rtl/atanh_iter.sv
// Iterative fixed-point atanh(x) in signed Q2.12 using an odd Taylor series in Horner form.
// A single shared 14x14 multiplier is time-multiplexed by the FSM; one transaction in flight.
module atanh_iter #(
    parameter logic signed [13:0] CLAMP_LIM = 14'sd2048
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [13:0] i_x,
    input  logic               i_valid,
    output logic               o_ready,
    output logic signed [13:0] o_fx,
    output logic               o_clamped,
    output logic               o_valid,
    input  logic               i_ready
);

    localparam logic signed [13:0] C9 = 14'sd455;
    localparam logic signed [13:0] C7 = 14'sd585;
    localparam logic signed [13:0] C5 = 14'sd819;
    localparam logic signed [13:0] C3 = 14'sd1365;

    typedef enum logic [2:0] {
        IDLE, SQUARE, HORNER, SCALE, MULX, FINAL, DONE
    } state_t;

    state_t             state_q;
    logic signed [13:0] x_q, x2_q, p_q, fx_q;
    logic [1:0]         cnt_q;
    logic               clamp_q, clamped_q, valid_q;

    logic signed [13:0] x_d;
    logic               clamp_d;
    logic signed [13:0] mul_a, mul_b, mul_res, coef;
    logic signed [27:0] prod;

    // Saturate the input to +/-CLAMP_LIM; the limit itself is not flagged.
    always_comb begin
        x_d     = i_x;
        clamp_d = 1'b0;
        if (i_x > CLAMP_LIM) begin
            x_d     = CLAMP_LIM;
            clamp_d = 1'b1;
        end else if (i_x < -CLAMP_LIM) begin
            x_d     = -CLAMP_LIM;
            clamp_d = 1'b1;
        end
    end

    always_comb begin
        mul_a = p_q;
        mul_b = x2_q;
        case (state_q)
            SQUARE:  begin mul_a = x_q; mul_b = x_q; end
            MULX:    begin mul_a = p_q; mul_b = x_q; end
            default: ;
        endcase
    end

    // Floor-truncating Q2.12 product: keep bits [25:12], drop the rest without saturation.
    assign prod    = mul_a * mul_b;
    assign mul_res = 14'(prod >>> 12);

    always_comb begin
        case (cnt_q)
            2'd0:    coef = C7;
            2'd1:    coef = C5;
            default: coef = C3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            x_q       <= '0;
            x2_q      <= '0;
            p_q       <= '0;
            cnt_q     <= '0;
            clamp_q   <= 1'b0;
            fx_q      <= '0;
            clamped_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        x_q     <= x_d;
                        clamp_q <= clamp_d;
                        p_q     <= C9;
                        cnt_q   <= '0;
                        state_q <= SQUARE;
                    end
                end
                SQUARE: begin
                    x2_q    <= mul_res;
                    state_q <= HORNER;
                end
                HORNER: begin
                    p_q   <= mul_res + coef;
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == 2'd2) state_q <= SCALE;
                end
                SCALE: begin
                    p_q     <= mul_res;
                    state_q <= MULX;
                end
                MULX: begin
                    p_q     <= mul_res;
                    state_q <= FINAL;
                end
                FINAL: begin
                    fx_q      <= p_q + x_q;
                    clamped_q <= clamp_q;
                    valid_q   <= 1'b1;
                    state_q   <= DONE;
                end
                DONE: begin
                    if (i_ready) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_ready   = (state_q == IDLE);
    assign o_fx      = fx_q;
    assign o_clamped = clamped_q;
    assign o_valid   = valid_q;

endmodule

// File: tb/tb_atanh_iter.sv
// Scoreboard bench for atanh_iter: directed vectors with hand-computed results,
// latency, backpressure and mid-transaction reset checks.
module tb_atanh_iter;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [13:0] i_x;
    logic               i_valid;
    logic               o_ready;
    logic signed [13:0] o_fx;
    logic               o_clamped;
    logic               o_valid;
    logic               i_ready;

    atanh_iter dut (
        .clk      (clk),
        .rst      (rst),
        .i_x      (i_x),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .o_fx     (o_fx),
        .o_clamped(o_clamped),
        .o_valid  (o_valid),
        .i_ready  (i_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [13:0] fx;
        logic               cl;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: an output handshake is seen at the negedge before the accepting edge.
    always @(negedge clk) begin
        if (!rst && o_valid && i_ready) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_output: got fx=%0d with empty scoreboard", o_fx);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("o_fx", int'(o_fx), int'(e.fx));
                chk("o_clamped", int'(o_clamped), int'(e.cl));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic signed [13:0] x, input logic push,
                          input logic signed [13:0] fx, input logic cl);
        int k;
        exp_t e;
        k = 0;
        while (!o_ready && k < 100) begin
            tick();
            k++;
        end
        if (!o_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: o_ready=%0d, expected 1", o_ready);
        end
        if (push) begin
            e.fx = fx;
            e.cl = cl;
            q.push_back(e);
        end
        i_x     = x;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
    endtask

    task automatic drain;
        int k;
        k = 0;
        while (q.size() != 0 && k < 60) begin
            tick();
            k++;
        end
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic wait_valid;
        int k;
        k = 0;
        while (!o_valid && k < 60) begin
            tick();
            k++;
        end
        if (!o_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL valid_timeout: o_valid=0, expected 1");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        i_x     = '0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_o_valid", int'(o_valid), 0);
        chk("rst_o_fx", int'(o_fx), 0);
        chk("rst_o_clamped", int'(o_clamped), 0);
        chk("rst_o_ready", int'(o_ready), 1);

        // x=0: exact zero result, o_valid rises after edge 7 and pulses one cycle.
        accept(14'sd0, 1'b1, 14'sd0, 1'b0);
        chk("lat_o_ready_busy", int'(o_ready), 0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("lat_o_valid_low", int'(o_valid), 0);
        end
        tick();
        chk("lat_o_valid_edge7", int'(o_valid), 1);
        tick();
        chk("pulse_o_valid", int'(o_valid), 0);
        chk("pulse_o_ready", int'(o_ready), 1);
        drain();

        accept(14'sd1024,  1'b1, 14'sd1046,  1'b0); drain();
        accept(-14'sd1024, 1'b1, -14'sd1046, 1'b0); drain();
        accept(14'sd2048,  1'b1, 14'sd2249,  1'b0); drain();
        accept(-14'sd2048, 1'b1, -14'sd2250, 1'b0); drain();
        accept(14'sd2049,  1'b1, 14'sd2249,  1'b1); drain();
        accept(14'sd3000,  1'b1, 14'sd2249,  1'b1); drain();
        accept(14'sd8191,  1'b1, 14'sd2249,  1'b1); drain();
        accept(-14'sd2049, 1'b1, -14'sd2250, 1'b1); drain();
        accept(-14'sd8192, 1'b1, -14'sd2250, 1'b1); drain();

        // Backpressure with i_valid held high the whole time.
        begin
            exp_t e;
            i_ready = 1'b0;
            i_x     = 14'sd1024;
            i_valid = 1'b1;
            e.fx = 14'sd1046; e.cl = 1'b0;
            q.push_back(e);
            tick();
            wait_valid();
            for (int k = 0; k < 20; k++) begin
                chk("bp_o_valid", int'(o_valid), 1);
                chk("bp_o_fx", int'(o_fx), 1046);
                chk("bp_o_ready", int'(o_ready), 0);
                tick();
            end
            i_ready = 1'b1;
            i_x     = 14'sd2048;
            e.fx = 14'sd2249; e.cl = 1'b0;
            q.push_back(e);
            tick();
            chk("bp_release_o_valid", int'(o_valid), 0);
            chk("bp_release_o_ready", int'(o_ready), 1);
            tick();
            chk("bp_reaccept_o_ready", int'(o_ready), 0);
            i_valid = 1'b0;
            drain();
        end

        // Reset while in HORNER discards the transaction.
        accept(14'sd1024, 1'b0, 14'sd0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_horner_o_valid", int'(o_valid), 0);
        chk("rst_horner_o_fx", int'(o_fx), 0);
        chk("rst_horner_o_ready", int'(o_ready), 1);

        // Reset while holding a result in DONE.
        i_ready = 1'b0;
        accept(14'sd3000, 1'b0, 14'sd0, 1'b0);
        wait_valid();
        chk("pre_rst_done_o_fx", int'(o_fx), 2249);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        i_ready = 1'b1;
        chk("rst_done_o_valid", int'(o_valid), 0);
        chk("rst_done_o_fx", int'(o_fx), 0);
        chk("rst_done_o_clamped", int'(o_clamped), 0);
        chk("rst_done_o_ready", int'(o_ready), 1);

        accept(14'sd1024, 1'b1, 14'sd1046, 1'b0);
        for (int k = 1; k <= 6; k++) tick();
        chk("post_rst_lat_low", int'(o_valid), 0);
        tick();
        chk("post_rst_lat_high", int'(o_valid), 1);
        drain();

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/atanh_iter.md
Name: atanh_iter

Overview:
- Fixed-point inverse hyperbolic tangent, f(x) = atanh(x); the decoding counterpart of the pipelined tanh block in the same activation-function datapath.
- Uses an odd Taylor series in Horner form: x + x^3/3 + x^5/5 + x^7/7 + x^9/9.
- Area-optimised: iterative, one shared 14x14 multiplier, FSM-sequenced.
- One transaction in flight; valid/ready handshake on both sides.

Parameters:
- CLAMP_LIM, 14'sd2048 (0.5 in Q2.12): input magnitude limit; inputs beyond it are saturated to ±CLAMP_LIM.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- i_x  input  14  input x, signed Q2.12
- i_valid  input  1  i_x valid
- o_ready  output  1  block can accept an input this cycle
- o_fx  output  14  atanh(x), signed Q2.12
- o_clamped  output  1  input was saturated; qualified by o_valid
- o_valid  output  1  o_fx/o_clamped valid
- i_ready  input  1  downstream accepts the output

Behaviour:
- Format: all values signed Q2.12.
- Coefficients: C9=455, C7=585, C5=819, C3=1365 (1/9, 1/7, 1/5, 1/3 truncated).
- mul(a,b): full 28-bit signed product, result = bits [25:12]. Truncation rounds toward -inf; upper bits are discarded, with no saturation.
- Adds: 14-bit two's-complement, wrapping.
- Reset: state=IDLE, o_valid=0, o_fx=0, o_clamped=0, cnt=0, internal x/x2/p=0. Reset wins over every other event, including mid-computation and during DONE; any in-flight result is discarded.
- o_ready = (state==IDLE). It is combinational from state only.
- FSM states: IDLE, SQUARE, HORNER, SCALE, MULX, FINAL, DONE.
- IDLE: on i_valid&&o_ready:
  - x <= clamp(i_x), where clamp gives +CLAMP_LIM if i_x>CLAMP_LIM, -CLAMP_LIM if i_x<-CLAMP_LIM, else i_x.
  - clamp flag <= (clamp applied).
  - p <= C9, cnt <= 0, go to SQUARE.
  - i_x/i_valid are otherwise ignored.
- SQUARE: x2 <= mul(x,x); go to HORNER.
- HORNER: p <= mul(p,x2) + coef[cnt], with coef[0]=C7, coef[1]=C5, coef[2]=C3. cnt increments; after cnt==2, go to SCALE. Exactly 3 cycles.
- SCALE: p <= mul(p,x2); go to MULX.
- MULX: p <= mul(p,x); go to FINAL.
- FINAL: o_fx <= p + x, o_clamped <= clamp flag, o_valid <= 1; go to DONE.
- DONE: holds o_fx, o_clamped, o_valid=1 stable until i_ready=1. On that edge: o_valid <= 0, go to IDLE. o_fx and o_clamped keep their last values.
- Latency: counting the accepting edge as 0, o_valid is high after edge 7.
- Throughput: at best one result per 9 cycles, since a new accept can occur at the edge after the output handshake.
- i_ready is ignored outside DONE. i_valid is ignored outside IDLE; no input is buffered.
- i_ready may be held high permanently: o_valid is then high for exactly 1 cycle.
- Boundaries:
  - x=0 yields exactly 0.
  - x=±CLAMP_LIM is not flagged; only strictly greater magnitudes are clamped.
  - x=-8192 clamps to -CLAMP_LIM.
  - Results are asymmetric for ±x because of floor truncation, and this is required.

Test Plan:
- Reset, then i_x=0, i_valid=1 for one cycle -> o_ready drops; after 7 edges o_valid=1, o_fx=0, o_clamped=0.
- i_x=1024 (0.25) -> x2=256; p sequence 613, 857, 1418, 88, 22; o_fx=1046, o_clamped=0.
- i_x=2048 -> o_fx=2249. i_x=-2048 -> o_fx=-2250 (floor asymmetry). o_clamped=0 for both.
- i_x=3000 -> o_fx=2249, o_clamped=1. i_x=-8192 -> o_fx=-2250, o_clamped=1.
- Backpressure case:
  - Stimulus: i_ready=0 for 20 cycles once o_valid rises, with i_valid held high throughout.
  - Required: o_fx and o_valid stay stable and o_ready stays 0 for the full 20 cycles.
  - On raising i_ready: o_valid falls after one edge, o_ready=1 on the next cycle, and the next accept occurs on that cycle.
- Assert rst during HORNER and again during DONE -> next cycle o_valid=0, o_fx=0, o_ready=1; a following i_x=1024 produces 1046 with normal latency.
